// File: rtl/booth_divider.sv
// ---------------------------------------------------------------------------
// booth_divider
//
// Sequential signed integer divider, companion to booth_multiplier. Divides a
// 2W-bit signed dividend by a W-bit signed divisor using radix-2 restoring
// division on magnitudes, one quotient bit per clock, then applies the result
// signs. The quotient truncates toward zero and the remainder takes the sign
// of the dividend.
//
// Optional build macro:
//   BOOTH_DIV_SAT_EN  - when defined, the single overflow case
//                       (-2^(2W-1) / -1) saturates Q to +2^(2W-1)-1;
//                       when undefined, Q wraps to -2^(2W-1).
//
// Ports:
//   clk    in   1    system clock, rising edge
//   rst    in   1    synchronous active-high reset
//   start  in   1    request, sampled only while idle
//   N      in   2W   signed dividend, captured on accept
//   D      in   W    signed divisor, captured on accept
//   Q      out  2W   signed quotient (held until next result)
//   R      out  W    signed remainder (held until next result)
//   busy   out  1    high while an operation is in flight
//   done   out  1    one-cycle pulse when Q/R/dbz/ovf are updated
//   dbz    out  1    divide-by-zero flag for the last result
//   ovf    out  1    overflow flag for the last result
// ---------------------------------------------------------------------------
module booth_divider #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2*W-1:0]   N,
    input  logic [W-1:0]     D,
    output logic [2*W-1:0]   Q,
    output logic [W-1:0]     R,
    output logic             busy,
    output logic             done,
    output logic             dbz,
    output logic             ovf
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    localparam int              CW     = $clog2(2*W) + 1;
    localparam logic [CW-1:0]   ITER   = CW'(2*W);
    localparam logic [2*W-1:0]  Q_MIN  = {1'b1, {(2*W-1){1'b0}}};
    localparam logic [2*W-1:0]  Q_MAX  = {1'b0, {(2*W-1){1'b1}}};

    state_t          r_state;
    logic [2*W-1:0]  r_quo;
    logic [W:0]      r_rem;
    logic [W:0]      r_dMag;
    logic [W-1:0]    r_nLow;
    logic [CW-1:0]   r_cnt;
    logic            r_qNeg;
    logic            r_rNeg;
    logic            r_dbz;
    logic            r_ovf;

    logic [2*W-1:0]  w_nMag;
    logic [W:0]      w_dExt;
    logic [W:0]      w_dMag;
    logic            w_isOvf;
    logic [W+1:0]    w_shift;
    logic [W+1:0]    w_trial;
    logic            w_fits;

    // Magnitudes of the operands. The divisor is sign-extended to W+1 bits
    // first so that the most negative divisor has a representable magnitude.
    // The dividend magnitude is treated as unsigned, so -2^(2W-1) maps to
    // 2^(2W-1) without loss.
    assign w_nMag  = N[2*W-1] ? -N : N;
    assign w_dExt  = {D[W-1], D};
    assign w_dMag  = D[W-1] ? -w_dExt : w_dExt;
    assign w_isOvf = (N == Q_MIN) && (D == '1);

    // One restoring step: shift the next dividend bit into the partial
    // remainder and trial-subtract |D|. The extra top bit of the trial
    // result acts as the borrow, so a clear MSB means the subtraction fits.
    assign w_shift = {r_rem, r_quo[2*W-1]};
    assign w_trial = w_shift - {1'b0, r_dMag};
    assign w_fits  = ~w_trial[W+1];

    // Control FSM and datapath. Outputs are registered and only change on
    // the FIX edge (or reset), so Q/R/flags stay stable through a following
    // operation. A divide by zero skips CALC entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_quo   <= '0;
            r_rem   <= '0;
            r_dMag  <= '0;
            r_nLow  <= '0;
            r_cnt   <= '0;
            r_qNeg  <= 1'b0;
            r_rNeg  <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            Q       <= '0;
            R       <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            dbz     <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_quo   <= w_nMag;
                        r_rem   <= '0;
                        r_dMag  <= w_dMag;
                        r_nLow  <= N[W-1:0];
                        r_cnt   <= ITER;
                        r_qNeg  <= N[2*W-1] ^ D[W-1];
                        r_rNeg  <= N[2*W-1];
                        r_dbz   <= (D == '0);
                        r_ovf   <= w_isOvf;
                        busy    <= 1'b1;
                        r_state <= (D == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    r_rem <= w_fits ? w_trial[W:0] : w_shift[W:0];
                    r_quo <= {r_quo[2*W-2:0], w_fits};
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= FIX;
                    end
                end
                FIX: begin
                    // Sign correction and special cases. The remainder
                    // magnitude is always below |D| <= 2^(W-1), so its low
                    // W bits carry the full value.
                    if (r_dbz) begin
                        Q   <= '1;
                        R   <= r_nLow;
                        dbz <= 1'b1;
                        ovf <= 1'b0;
                    end else if (r_ovf) begin
`ifdef BOOTH_DIV_SAT_EN
                        Q   <= Q_MAX;
`else
                        Q   <= Q_MIN;
`endif
                        R   <= '0;
                        dbz <= 1'b0;
                        ovf <= 1'b1;
                    end else begin
                        Q   <= r_qNeg ? -r_quo : r_quo;
                        R   <= r_rNeg ? -r_rem[W-1:0] : r_rem[W-1:0];
                        dbz <= 1'b0;
                        ovf <= 1'b0;
                    end
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
